// File: rtl/sw_debounce_pkg.sv
// Shared constants and helpers for the switch debouncer.
// Counter width derives from the acceptance threshold so one package serves every build.
package sw_debounce_pkg;

   localparam int DB_CYCLES_10MS_100MHZ = 1000000;
   localparam int DB_CYCLES_SIM         = 4;

   // Counter must be able to hold DB_CYCLES-1; threshold values below 1 are illegal.
   function automatic int cnt_width(input int db_cycles);
      return (db_cycles < 1) ? 1 : $clog2(db_cycles + 1);
   endfunction

endpackage

// File: rtl/sw_debounce_if.sv
// Switch bundle between the board pins and the debouncer.
// There is no handshake: sw_raw is an async level, sw_db is a registered level, sw_rise/sw_fall are one-cycle strobes.
interface sw_debounce_if #(
   parameter int WIDTH = 2
);
   logic [WIDTH-1:0] sw_raw;
   logic [WIDTH-1:0] sw_db;
   logic [WIDTH-1:0] sw_rise;
   logic [WIDTH-1:0] sw_fall;

   modport master (output sw_raw, input sw_db, input sw_rise, input sw_fall);
   modport slave  (input sw_raw, output sw_db, output sw_rise, output sw_fall);
endinterface

// File: rtl/sw_debounce_db_bit.sv
// One switch bit: two-flop synchroniser, persistence counter and optional edge-pulse registers.
// Edge pulses are built only when SW_DEBOUNCE_EDGE_EN is defined.
module db_bit
   import sw_debounce_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_10MS_100MHZ
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_i,
   output logic db_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int CW = cnt_width(DB_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

   logic          s1_q, s2_q;
   logic          db_q, db_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          accept;

   // Clearing on acceptance or on a return to the held level keeps the counter from ever wrapping.
   always_comb begin
      accept = (s2_q != db_q) && (cnt_q == LAST);
      db_d   = accept ? s2_q : db_q;
      cnt_d  = cnt_q + CW'(1);
      if ((s2_q == db_q) || accept) cnt_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q  <= 1'b0;
         s2_q  <= 1'b0;
         db_q  <= 1'b0;
         cnt_q <= '0;
      end else begin
         s1_q  <= raw_i;
         s2_q  <= s1_q;
         db_q  <= db_d;
         cnt_q <= cnt_d;
      end
   end

   assign db_o = db_q;

`ifdef SW_DEBOUNCE_EDGE_EN
   logic rise_q, fall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= accept && s2_q;
         fall_q <= accept && !s2_q;
      end
   end

   assign rise_o = rise_q;
   assign fall_o = fall_q;
`else
   assign rise_o = 1'b0;
   assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/sw_debounce.sv
// Debounces WIDTH independent slide switches into clean registered levels and optional edge strobes.
// Define SW_DEBOUNCE_EDGE_EN to build the sw_rise/sw_fall registers; otherwise they read 0.
module sw_debounce
   import sw_debounce_pkg::*;
#(
   parameter int WIDTH     = 2,
   parameter int DB_CYCLES = DB_CYCLES_10MS_100MHZ
) (
   input  logic          clk,
   input  logic          rst_n,
   sw_debounce_if.slave  bus
);

   logic [WIDTH-1:0] db_w;
   logic [WIDTH-1:0] rise_w;
   logic [WIDTH-1:0] fall_w;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      db_bit #(
         .DB_CYCLES (DB_CYCLES)
      ) u_db_bit (
         .clk    (clk),
         .rst_n  (rst_n),
         .raw_i  (bus.sw_raw[i]),
         .db_o   (db_w[i]),
         .rise_o (rise_w[i]),
         .fall_o (fall_w[i])
      );
   end

   assign bus.sw_db   = db_w;
   assign bus.sw_rise = rise_w;
   assign bus.sw_fall = fall_w;

endmodule
